ram_w_sched: RTL and testbench

Frame-level scheduler for the burst write master. It accepts one frame descriptor per handshake: base address, line stride, bursts per line and line count. It then runs the write master one line at a time: one start pulse carrying the line's address and burst count, then wait for the master to go idle. It also gates the upstream pixel producer, and reports line/frame completion to the Sobel control logic.

---
 rtl/ram_w_sched_pkg.sv | 17 +
 rtl/ram_w_sched.sv | 121 ++++++++++++
 tb/tb_ram_w_sched.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_w_sched_pkg.sv
// Shared state encoding and default widths for the frame-level write scheduler.
package ram_w_sched_pkg;

    localparam int unsigned DefAddWidth    = 32;
    localparam int unsigned DefDataWidth   = 32;
    localparam int unsigned DefBurstsWidth = 16;
    localparam int unsigned DefLinesWidth  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRun,
        StNext,
        StFin
    } state_e;

endpackage

// File: rtl/ram_w_sched.sv
// Frame scheduler: walks a frame descriptor line by line, issuing one start pulse per line
// to the burst write master and waiting for it to drain before moving on.
module ram_w_sched
    import ram_w_sched_pkg::*;
#(
    parameter int unsigned ADD_WIDTH    = DefAddWidth,
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned BURSTS_WIDTH = DefBurstsWidth,
    parameter int unsigned LINES_WIDTH  = DefLinesWidth
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [ADD_WIDTH-1:0]    cfg_base,
    input  logic [ADD_WIDTH-1:0]    cfg_stride,
    input  logic [BURSTS_WIDTH-1:0] cfg_line_bursts,
    input  logic [LINES_WIDTH-1:0]  cfg_lines,
    input  logic                    abort,
    output logic                    start_fifo_out,
    output logic [ADD_WIDTH-1:0]    address_fifo_out,
    output logic [DATA_WIDTH-1:0]   n_burst_fifo_out,
    input  logic                    bussy_fifo_out,
    input  logic                    full_fifo_out,
    output logic                    src_ready,
    output logic                    busy,
    output logic [LINES_WIDTH-1:0]  cur_line,
    output logic                    line_done,
    output logic                    frame_done,
    output logic                    aborted
);

    state_e                  state_q, state_d;
    logic [ADD_WIDTH-1:0]    addr_q, addr_d;
    logic [ADD_WIDTH-1:0]    stride_q, stride_d;
    logic [BURSTS_WIDTH-1:0] bursts_q, bursts_d;
    logic [LINES_WIDTH-1:0]  lines_q, lines_d;
    logic [LINES_WIDTH-1:0]  cur_line_q, cur_line_d;
    logic                    abort_q, abort_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        bursts_d   = bursts_q;
        lines_d    = lines_q;
        cur_line_d = cur_line_q;
        // Abort only takes effect at a line boundary, so remember it until then.
        abort_d    = abort_q | (abort & (state_q != StIdle));
        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    addr_d     = cfg_base;
                    stride_d   = cfg_stride;
                    bursts_d   = cfg_line_bursts;
                    lines_d    = cfg_lines;
                    cur_line_d = '0;
                    abort_d    = 1'b0;
                    if ((cfg_lines == '0) || (cfg_line_bursts == '0)) begin
                        state_d = StFin;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StStart: state_d = StRun;
            StRun: begin
                if (!bussy_fifo_out) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (abort_q) begin
                    abort_d = 1'b0;
                    state_d = StIdle;
                end else if (cur_line_q == (lines_q - LINES_WIDTH'(1))) begin
                    state_d = StFin;
                end else begin
                    cur_line_d = cur_line_q + LINES_WIDTH'(1);
                    addr_d     = addr_q + stride_q;
                    state_d    = StStart;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            stride_q   <= '0;
            bursts_q   <= '0;
            lines_q    <= '0;
            cur_line_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            bursts_q   <= bursts_d;
            lines_q    <= lines_d;
            cur_line_q <= cur_line_d;
            abort_q    <= abort_d;
        end
    end

    // NEXT is entered only from RUN when the master drains, so it marks a finished line.
    assign cfg_ready        = (state_q == StIdle);
    assign busy             = (state_q != StIdle);
    assign start_fifo_out   = (state_q == StStart);
    assign address_fifo_out = addr_q;
    assign n_burst_fifo_out = DATA_WIDTH'(bursts_q);
    assign cur_line         = cur_line_q;
    assign line_done        = (state_q == StNext);
    assign aborted          = (state_q == StNext) & abort_q;
    assign frame_done       = (state_q == StFin);
    assign src_ready        = (state_q == StRun) & ~full_fifo_out;

endmodule

// File: tb/tb_ram_w_sched.sv
// Bench for ram_w_sched: per-frame expected event timeline built from line durations,
// compared every cycle against the scheduler outputs.
module tb_ram_w_sched;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_base;
    logic [31:0] cfg_stride;
    logic [15:0] cfg_line_bursts;
    logic [15:0] cfg_lines;
    logic        abort;
    logic        start_fifo_out;
    logic [31:0] address_fifo_out;
    logic [31:0] n_burst_fifo_out;
    logic        bussy_fifo_out;
    logic        full_fifo_out;
    logic        src_ready;
    logic        busy;
    logic [15:0] cur_line;
    logic        line_done;
    logic        frame_done;
    logic        aborted;

    int n_cmp  = 0;
    int n_fail = 0;

    ram_w_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_base         (cfg_base),
        .cfg_stride       (cfg_stride),
        .cfg_line_bursts  (cfg_line_bursts),
        .cfg_lines        (cfg_lines),
        .abort            (abort),
        .start_fifo_out   (start_fifo_out),
        .address_fifo_out (address_fifo_out),
        .n_burst_fifo_out (n_burst_fifo_out),
        .bussy_fifo_out   (bussy_fifo_out),
        .full_fifo_out    (full_fifo_out),
        .src_ready        (src_ready),
        .busy             (busy),
        .cur_line         (cur_line),
        .line_done        (line_done),
        .frame_done       (frame_done),
        .aborted          (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cfg_ready"}, 64'(cfg_ready), 64'd1);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".start"}, 64'(start_fifo_out), 64'd0);
        check({tag, ".addr"}, 64'(address_fifo_out), 64'd0);
        check({tag, ".n_burst"}, 64'(n_burst_fifo_out), 64'd0);
        check({tag, ".cur_line"}, 64'(cur_line), 64'd0);
        check({tag, ".src_ready"}, 64'(src_ready), 64'd0);
        check({tag, ".line_done"}, 64'(line_done), 64'd0);
        check({tag, ".frame_done"}, 64'(frame_done), 64'd0);
        check({tag, ".aborted"}, 64'(aborted), 64'd0);
    endtask

    // Cycle 0 is the handshake cycle. A line started at cycle s keeps the master busy for
    // cycles s+1..s+r, completes at s+r+2, and the next line (or frame end) follows at s+r+3.
    task automatic run_frame(input logic [31:0] base, input logic [31:0] stride,
                             input logic [15:0] bursts, input logic [15:0] lines,
                             input int abort_line, input int unsigned abort_off,
                             input bit hold, input int r_fixed);
        bit e_st[512];
        bit e_ld[512];
        bit e_fd[512];
        bit e_ab[512];
        bit e_bz[512];
        bit e_run[512];
        bit e_mb[512];
        int e_line[512];
        int end_c;
        int s;
        int n;
        int rk;
        int ab_c;
        logic [31:0] ea;
        e_st  = '{default: 1'b0};
        e_ld  = '{default: 1'b0};
        e_fd  = '{default: 1'b0};
        e_ab  = '{default: 1'b0};
        e_bz  = '{default: 1'b0};
        e_run = '{default: 1'b0};
        e_mb  = '{default: 1'b0};
        e_line = '{default: 0};
        ab_c  = -1;
        end_c = 1;
        if ((lines == 16'd0) || (bursts == 16'd0)) begin
            e_fd[1] = 1'b1;
        end else begin
            s = 1;
            for (int k = 0; k < int'(lines); k++) begin
                rk = (r_fixed > 0) ? r_fixed : int'($urandom_range(1, 8));
                e_st[s]   = 1'b1;
                e_line[s] = k;
                for (int c = s + 1; c <= s + rk; c++) e_mb[c] = 1'b1;
                for (int c = s + 1; c <= s + rk + 1; c++) e_run[c] = 1'b1;
                n = s + rk + 2;
                e_ld[n] = 1'b1;
                if (k == abort_line) begin
                    ab_c    = s + int'(abort_off % 32'(rk + 2));
                    e_ab[n] = 1'b1;
                    end_c   = n;
                    break;
                end
                if (k == int'(lines) - 1) begin
                    e_fd[n + 1] = 1'b1;
                    end_c       = n + 1;
                    break;
                end
                s = n + 1;
            end
        end
        for (int c = 1; c <= end_c; c++) e_bz[c] = 1'b1;

        // Idle cycle with abort possibly high: must be ignored and not leak into the frame.
        @(negedge clk);
        cfg_valid      = 1'b0;
        abort          = 1'($urandom_range(0, 1));
        bussy_fifo_out = 1'b0;
        full_fifo_out  = 1'($urandom_range(0, 1));
        #1;
        check("idle.cfg_ready", 64'(cfg_ready), 64'd1);
        check("idle.busy", 64'(busy), 64'd0);
        check("idle.start", 64'(start_fifo_out), 64'd0);

        for (int c = 0; c <= end_c + 1; c++) begin
            @(negedge clk);
            cfg_valid = (c == 0) || (hold && (c <= end_c));
            if (c == 0) begin
                cfg_base        = base;
                cfg_stride      = stride;
                cfg_line_bursts = bursts;
                cfg_lines       = lines;
            end else begin
                cfg_base        = $urandom;
                cfg_stride      = $urandom;
                cfg_line_bursts = 16'($urandom);
                cfg_lines       = 16'($urandom);
            end
            abort          = (c == ab_c);
            bussy_fifo_out = e_mb[c];
            full_fifo_out  = 1'($urandom_range(0, 1));
            #1;
            check("start", 64'(start_fifo_out), 64'(e_st[c]));
            check("line_done", 64'(line_done), 64'(e_ld[c]));
            check("frame_done", 64'(frame_done), 64'(e_fd[c]));
            check("aborted", 64'(aborted), 64'(e_ab[c]));
            check("busy", 64'(busy), 64'(e_bz[c]));
            check("cfg_ready", 64'(cfg_ready), 64'(!e_bz[c]));
            check("src_ready", 64'(src_ready), 64'(e_run[c] && !full_fifo_out));
            if (e_st[c]) begin
                ea = base + stride * 32'(e_line[c]);
                check("address", 64'(address_fifo_out), 64'(ea));
                check("n_burst", 64'(n_burst_fifo_out), 64'(bursts));
                check("cur_line", 64'(cur_line), 64'(e_line[c]));
            end
        end
        cfg_valid = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        cfg_valid       = 1'b0;
        cfg_base        = '0;
        cfg_stride      = '0;
        cfg_line_bursts = '0;
        cfg_lines       = '0;
        abort           = 1'b0;
        bussy_fifo_out  = 1'b0;
        full_fifo_out   = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(32'h1000, 32'h200, 16'd2, 16'd1, -1, 0, 1'b0, 64);
        run_frame(32'h1000, 32'h200, 16'd3, 16'd3, -1, 0, 1'b0, 0);
        run_frame(32'h1000, 32'h200, 16'd2, 16'd0, -1, 0, 1'b0, 0);
        run_frame(32'h1000, 32'h200, 16'd0, 16'd3, -1, 0, 1'b0, 0);
        run_frame(32'h2000, 32'h80, 16'd4, 16'd4, 1, $urandom, 1'b0, 0);
        run_frame(32'h3000, 32'h40, 16'd1, 16'd2, 1, $urandom, 1'b0, 0);
        run_frame(32'hFFFF_FF00, 32'h200, 16'd5, 16'd2, -1, 0, 1'b1, 0);

        // Reset asserted while the master is mid-line.
        @(negedge clk);
        cfg_base        = 32'h4000;
        cfg_stride      = 32'h100;
        cfg_line_bursts = 16'd7;
        cfg_lines       = 16'd3;
        cfg_valid       = 1'b1;
        full_fifo_out   = 1'b0;
        bussy_fifo_out  = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        bussy_fifo_out = 1'b1;
        #1;
        check("rst_run.src_ready", 64'(src_ready), 64'd1);
        check("rst_run.busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        bussy_fifo_out = 1'b0;
        rst_n          = 1'b1;

        for (int i = 0; i < 25; i++) begin
            run_frame($urandom, $urandom, 16'($urandom_range(0, 9)),
                      16'($urandom_range(0, 5)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1,
                      $urandom, 1'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
